// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage issue control bundle: ID decode and writeback inputs, issue/stall/flush/halt outputs.
interface id_hazard_ctrl_if;
  logic       i_valid;
  logic [3:0] i_rdReg1;
  logic       i_rdReg1En;
  logic [3:0] i_rdReg2;
  logic       i_rdReg2En;
  logic [3:0] i_wrReg;
  logic       i_wrRegEn;
  logic       i_sawBr;
  logic       i_brTaken;
  logic       i_sawJ;
  logic       i_hlt;
  logic [3:0] i_wbReg;
  logic       i_wbEn;
  logic       o_issue;
  logic       o_stall;
  logic       o_flush;
  logic       o_haltDone;
  logic [1:0] o_state;

  modport master (
    output i_valid, i_rdReg1, i_rdReg1En, i_rdReg2, i_rdReg2En, i_wrReg, i_wrRegEn,
           i_sawBr, i_brTaken, i_sawJ, i_hlt, i_wbReg, i_wbEn,
    input  o_issue, o_stall, o_flush, o_haltDone, o_state
  );

  modport slave (
    input  i_valid, i_rdReg1, i_rdReg1En, i_rdReg2, i_rdReg2En, i_wrReg, i_wrRegEn,
           i_sawBr, i_brTaken, i_sawJ, i_hlt, i_wbReg, i_wbEn,
    output o_issue, o_stall, o_flush, o_haltDone, o_state
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage issue controller: RAW scoreboard, redirect flush window and halt drain sequencing.
module id_hazard_ctrl #(
  parameter int NREGS     = 16,
  parameter int FLUSH_CYC = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  id_hazard_ctrl_if.slave      bus
);

  localparam int CW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NREGS-1:0] busy_reg, busy_next, busy_eff;
  logic             hazard;
  logic             issue;
  logic             redirect;

  // Register file writes before it reads, so a same-cycle writeback hides the hazard.
  assign busy_eff[0]  = 1'b0;
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_sb
      logic clr, set;
      assign clr           = bus.i_wbEn && (bus.i_wbReg == gi[3:0]);
      assign set           = issue && bus.i_wrRegEn && (bus.i_wrReg == gi[3:0]);
      assign busy_eff[gi]  = busy_reg[gi] && !clr;
      assign busy_next[gi] = set || (busy_reg[gi] && !clr);
    end
  endgenerate

  assign hazard = (bus.i_rdReg1En && busy_eff[bus.i_rdReg1]) ||
                  (bus.i_rdReg2En && busy_eff[bus.i_rdReg2]);

  assign issue    = !i_rst && (state_reg == RUN) && bus.i_valid && !hazard;
  assign redirect = bus.i_sawJ || (bus.i_sawBr && bus.i_brTaken);

  assign bus.o_issue    = issue;
  assign bus.o_stall    = !i_rst && (((state_reg == RUN) && bus.i_valid && hazard) ||
                                     (state_reg == DRAIN) || (state_reg == HALTED));
  assign bus.o_flush    = (state_reg == FLUSH);
  assign bus.o_haltDone = (state_reg == HALTED);
  assign bus.o_state    = state_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      busy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      RUN: begin
        // HLT wins over a redirect in the same instruction.
        if (issue && bus.i_hlt) begin
          state_next = DRAIN;
        end else if (issue && redirect) begin
          state_next = FLUSH;
          cnt_next   = CW'(FLUSH_CYC);
        end
      end
      FLUSH: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (busy_next == '0) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Issue controller for the decode (ID) stage.
- Keeps a per-register scoreboard of writes that have been issued but not yet written back.
- Stalls ID on read-after-write hazards and flushes fetch/decode after taken branches and jumps.
- Sequences the halt drain so the register file is quiescent before the halt is reported.
- Sits between ID control decode and the pipeline stage registers.

Parameters:
- NREGS, 16, number of architectural registers; register 0 is hardwired zero.
- FLUSH_CYC, 2, number of cycles o_flush stays asserted after a redirect.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous reset, active-high
- i_valid  input  1  ID holds a decoded instruction
- i_rdReg1  input  4  source register 1
- i_rdReg1En  input  1  source 1 is read
- i_rdReg2  input  4  source register 2
- i_rdReg2En  input  1  source 2 is read
- i_wrReg  input  4  destination register
- i_wrRegEn  input  1  instruction writes i_wrReg
- i_sawBr  input  1  instruction is a branch
- i_brTaken  input  1  branch resolved taken; qualified by i_sawBr
- i_sawJ  input  1  instruction is a jump
- i_hlt  input  1  instruction is HLT
- i_wbReg  input  4  writeback destination
- i_wbEn  input  1  writeback occurs this cycle
- o_issue  output  1  ID instruction advances this cycle
- o_stall  output  1  hold PC and the IF/ID register
- o_flush  output  1  squash IF/ID contents
- o_haltDone  output  1  core halted and drained
- o_state  output  2  FSM state: 0 RUN, 1 FLUSH, 2 DRAIN, 3 HALTED

Behaviour:
- Reset (async, i_rst=1):
  - busy[NREGS-1:0]=0, state=RUN, flush counter=0.
  - o_issue=0, o_stall=0, o_flush=0, o_haltDone=0.
- Hazard (combinational):
  - hazard = (i_rdReg1En && busyEff[i_rdReg1]) || (i_rdReg2En && busyEff[i_rdReg2]).
  - busyEff[r] = busy[r] && !(i_wbEn && i_wbReg==r). The register file writes before it reads, so a same-cycle writeback clears the hazard.
  - busyEff[0] is always 0.
- Issue (combinational):
  - o_issue = (state==RUN) && i_valid && !hazard.
  - o_stall = (state==RUN && i_valid && hazard) || state==DRAIN || state==HALTED.
- Scoreboard update (each clock):
  - Writeback clears busy[i_wbReg].
  - o_issue && i_wrRegEn && i_wrReg!=0 sets busy[i_wrReg].
  - If set and clear target the same register in the same cycle, set wins.
  - Writes to register 0 never set a bit. A writeback to a non-busy register is harmless.
- FSM:
  - RUN:
    - o_issue && i_hlt goes to DRAIN. HLT has priority over branch and jump.
    - o_issue && (i_sawJ || (i_sawBr && i_brTaken)) goes to FLUSH and loads counter=FLUSH_CYC.
    - Otherwise stay in RUN.
  - FLUSH:
    - o_flush=1 (Moore, from state); counter decrements each cycle.
    - When counter==1, go to RUN. Exactly FLUSH_CYC flush cycles follow the redirect.
    - No issue in FLUSH; the scoreboard still clears on writeback.
  - DRAIN:
    - No issue. Go to HALTED on the first clock edge where busy==0 after that cycle's clear.
    - If busy is already 0 on entry, HALTED follows after one cycle.
  - HALTED:
    - o_haltDone=1, registered and sticky. o_stall=1. Leave only on reset.
- A not-taken branch (i_sawBr && !i_brTaken) issues normally with no flush.
- i_valid=0 in RUN: no issue, no stall, no state change.
- Reset asserted mid-FLUSH or mid-DRAIN returns immediately to RUN, clears the scoreboard and drops all outputs; in-flight writebacks after reset are ignored.

Test Plan:
1. Reset mid-DRAIN with busy[5]=1 -> o_state=0, o_stall=0, o_haltDone=0 immediately (asynchronous); busy=0 after release.
2. Issue "wr R3", then next cycle a read of R3 with i_rdReg1En=1 and no writeback -> o_stall=1, o_issue=0. Assert i_wbEn, i_wbReg=3 -> same cycle o_stall=0, o_issue=1.
3. Issue a write to R0, then a read of R0 -> no stall. Same-cycle wb of R7 and issue of a new write to R7 -> busy[7]=1 after the edge; a following read of R7 stalls.
4. Issue a jump with FLUSH_CYC=2 -> o_flush=1 for exactly 2 cycles and o_issue=0 in both; o_issue=1 in the third cycle with i_valid=1. A not-taken branch gives o_flush=0.
5. Issue HLT with busy[4]=1 and busy[9]=1 -> o_state=2, o_stall=1. wb R4 then wb R9 -> o_haltDone=1 on the edge after the R9 writeback and stays 1 for 10 more cycles.
6. Issue HLT with i_sawJ=1 in the same instruction -> DRAIN is entered, not FLUSH, and o_flush stays 0.
